// File: rtl/sprite_linebuf_pkg.sv
// Shared constants, state encoding and pixel helpers for the sprite line buffer.
package sprite_linebuf_pkg;

  localparam int PIX_W = 11;
  localparam int AW    = 9;
  localparam int XMAX  = 383;

  localparam logic [AW-1:0] XMAX_ADDR   = XMAX[AW-1:0];
  localparam logic [3:0]    TRANSP_MASK = 4'hF;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Colour code 0 marks a transparent pixel that must not overwrite the line.
  function automatic logic is_opaque(input logic [PIX_W-1:0] pix);
    return (pix[3:0] & TRANSP_MASK) != 4'h0;
  endfunction

endpackage

// File: rtl/sprite_linebuf_if.sv
// Video timing, renderer write port and display outputs of the sprite line buffer.
interface sprite_linebuf_if;
  import sprite_linebuf_pkg::*;

  logic             clk_pix;
  logic [8:0]       hc;
  logic [8:0]       vc;
  logic             hbl;
  logic             vbl;
  logic             wr_en;
  logic [8:0]       wr_x;
  logic [PIX_W-1:0] wr_data;
  logic             line_req;
  logic [8:0]       line_num;
  logic [PIX_W-1:0] pix_out;
  logic             init_done;

  modport master (
    output clk_pix, hc, vc, hbl, vbl, wr_en, wr_x, wr_data,
    input  line_req, line_num, pix_out, init_done
  );

  modport slave (
    input  clk_pix, hc, vc, hbl, vbl, wr_en, wr_x, wr_data,
    output line_req, line_num, pix_out, init_done
  );

endinterface

// File: rtl/sprite_linebuf_bank.sv
// Single-port line bank: one access per clk, write or registered read.
module linebuf_bank
  import sprite_linebuf_pkg::*;
(
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer: renderer draws one bank while the other
// is scanned out at hc and cleared behind the beam; banks swap on hblank entry.
module sprite_linebuf
  import sprite_linebuf_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  sprite_linebuf_if.slave bus
);

  state_t           state, state_nxt;
  logic [AW-1:0]    init_addr;
  logic             bank_sel, hbl_d;
  logic             line_req, init_done;
  logic [8:0]       line_num;
  logic [PIX_W-1:0] pix_out;

  logic             run, scan_p0, swap_p0, wr_ok_p0, draw_bank;
  logic             rd_vld_p1, rd_bank_p1, blank_p1;
  logic [AW-1:0]    rd_addr_p1;

  logic             pend_vld, pend_bank;
  logic [AW-1:0]    pend_addr;
  logic [PIX_W-1:0] pend_data;
  logic [1:0]       clr_busy, rd_busy;
  logic             pend_go, new_go;

  logic [1:0]       bk_en, bk_we;
  logic [AW-1:0]    bk_addr  [2];
  logic [PIX_W-1:0] bk_wdata [2];
  logic [PIX_W-1:0] bk_rdata [2];

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_addr == '1) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign run       = (state == RUN);
  assign scan_p0   = run & bus.clk_pix;
  assign swap_p0   = scan_p0 & bus.hbl & ~hbl_d;
  assign draw_bank = ~bank_sel;
  assign wr_ok_p0  = run & bus.wr_en & (bus.wr_x <= XMAX_ADDR) & is_opaque(bus.wr_data);

  // The clear behind a swap lands on the new draw bank; a draw write that
  // collides with it waits one clk in the pending slot, keeping write order.
  assign clr_busy = {2{rd_vld_p1}} & (2'b01 << rd_bank_p1);
  assign rd_busy  = {2{scan_p0}} & (2'b01 << bank_sel);
  assign pend_go  = pend_vld & ~clr_busy[pend_bank] & ~rd_busy[pend_bank];
  assign new_go   = wr_ok_p0 & ~clr_busy[draw_bank] & ~rd_busy[draw_bank]
                  & ~(pend_vld & (pend_bank == draw_bank));

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bk_en[b]    = 1'b0;
      bk_we[b]    = 1'b0;
      bk_addr[b]  = '0;
      bk_wdata[b] = '0;
      if (!run) begin
        bk_en[b]   = 1'b1;
        bk_we[b]   = 1'b1;
        bk_addr[b] = init_addr;
      end else if (clr_busy[b]) begin
        bk_en[b]   = 1'b1;
        bk_we[b]   = 1'b1;
        bk_addr[b] = rd_addr_p1;
      end else if (rd_busy[b]) begin
        bk_en[b]   = 1'b1;
        bk_addr[b] = bus.hc;
      end else if (pend_go && (pend_bank == b[0])) begin
        bk_en[b]    = 1'b1;
        bk_we[b]    = 1'b1;
        bk_addr[b]  = pend_addr;
        bk_wdata[b] = pend_data;
      end else if (new_go && (draw_bank == b[0])) begin
        bk_en[b]    = 1'b1;
        bk_we[b]    = 1'b1;
        bk_addr[b]  = bus.wr_x;
        bk_wdata[b] = bus.wr_data;
      end
    end
  end

  linebuf_bank u_bank0 (
    .clk   (clk),
    .en    (bk_en[0]),
    .we    (bk_we[0]),
    .addr  (bk_addr[0]),
    .wdata (bk_wdata[0]),
    .rdata (bk_rdata[0])
  );

  linebuf_bank u_bank1 (
    .clk   (clk),
    .en    (bk_en[1]),
    .we    (bk_we[1]),
    .addr  (bk_addr[1]),
    .wdata (bk_wdata[1]),
    .rdata (bk_rdata[1])
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      init_addr  <= '0;
      bank_sel   <= 1'b0;
      hbl_d      <= 1'b0;
      line_req   <= 1'b0;
      line_num   <= '0;
      init_done  <= 1'b0;
      pix_out    <= '0;
      rd_vld_p1  <= 1'b0;
      pend_vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_addr <= init_addr + AW'(1);
      if (state == INIT && state_nxt == RUN) init_done <= 1'b1;
      if (bus.clk_pix) hbl_d <= bus.hbl;
      line_req <= swap_p0;
      if (swap_p0) begin
        line_num <= bus.vc + 9'd1;
        bank_sel <= ~bank_sel;
      end
      // p0 -> p1: read issued on clk_pix, data and clear land one clk later
      rd_vld_p1 <= scan_p0;
      if (rd_vld_p1) pix_out <= blank_p1 ? '0 : bk_rdata[rd_bank_p1];
      pend_vld <= (pend_vld & ~pend_go) | (wr_ok_p0 & ~new_go);
    end
  end

  always_ff @(posedge clk) begin
    if (scan_p0) begin
      rd_addr_p1 <= bus.hc;
      rd_bank_p1 <= bank_sel;
      blank_p1   <= bus.hbl | bus.vbl;
    end
    if (wr_ok_p0 && !new_go) begin
      pend_bank <= draw_bank;
      pend_addr <= bus.wr_x;
      pend_data <= bus.wr_data;
    end
  end

  assign bus.line_req  = line_req;
  assign bus.line_num  = line_num;
  assign bus.pix_out   = pix_out;
  assign bus.init_done = init_done;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Line-by-line bench: drives video timing and renderer writes, checks displayed pixels.
module tb_sprite_linebuf;
  import sprite_linebuf_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sprite_linebuf_if bus ();

  sprite_linebuf dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [8:0]       wx;
    logic [PIX_W-1:0] wd;
  } wr_t;

  typedef struct {
    logic [8:0]       wx;
    logic [PIX_W-1:0] wd;
    logic [8:0]       cx;
    logic [PIX_W-1:0] cexp;
  } vec_t;

  int               checks = 0;
  int               errors = 0;
  logic [PIX_W-1:0] exp_q [$];
  wr_t              wq [$];
  logic [PIX_W-1:0] exp_disp [XMAX+1];
  vec_t             vecs [8];
  logic             prev_hbl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_wr(input logic [8:0] x, input logic [PIX_W-1:0] d);
    wr_t w;
    w.wx = x;
    w.wd = d;
    wq.push_back(w);
  endtask

  task automatic zero_exp();
    for (int i = 0; i <= XMAX; i++) exp_disp[i] = '0;
  endtask

  task automatic drive_idle();
    bus.clk_pix = 1'b0;
    bus.hc      = '0;
    bus.vc      = '0;
    bus.hbl     = 1'b0;
    bus.vbl     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_x    = '0;
    bus.wr_data = '0;
  endtask

  // One pixel = clk_pix clk plus one idle clk; pix_out of the previous pixel
  // is checked at the start of the next one.
  task automatic pixel(input logic [8:0] hc, input logic [8:0] vc, input logic vbl);
    logic             swap;
    logic [8:0]       ln;
    logic [PIX_W-1:0] e;
    wr_t              w;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (exp_q.size() > 0) chk("pix_out", bus.pix_out, exp_q.pop_front());
    bus.clk_pix = 1'b1;
    bus.hc      = hc;
    bus.vc      = vc;
    bus.hbl     = (hc >= 9'd320);
    bus.vbl     = vbl;
    e = (bus.hbl || vbl) ? '0 : exp_disp[hc];
    exp_q.push_back(e);
    swap     = bus.hbl && !prev_hbl;
    prev_hbl = bus.hbl;
    ln       = vc + 9'd1;
    @(negedge clk);
    bus.clk_pix = 1'b0;
    chk("line_req", bus.line_req, swap);
    if (swap) chk("line_num", bus.line_num, ln);
    if (wq.size() > 0 && hc < 9'd300) begin
      w = wq.pop_front();
      bus.wr_en   = 1'b1;
      bus.wr_x    = w.wx;
      bus.wr_data = w.wd;
    end
  endtask

  task automatic run_line(input logic [8:0] vc, input logic vbl, input int stop);
    for (int h = 0; h < stop; h++) pixel(9'(h), vc, vbl);
  endtask

  task automatic flush();
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.clk_pix = 1'b0;
    if (exp_q.size() > 0) chk("pix_out_last", bus.pix_out, exp_q.pop_front());
  endtask

  task automatic reset_init();
    reset_n = 1'b0;
    drive_idle();
    prev_hbl = 1'b0;
    exp_q.delete();
    wq.delete();
    repeat (2) @(negedge clk);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_pix_out", bus.pix_out, 0);
    chk("rst_line_req", bus.line_req, 0);
    chk("rst_line_num", bus.line_num, 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      chk("init_done", bus.init_done, (k == 512));
      chk("init_pix_out", bus.pix_out, 0);
    end
  endtask

  initial begin
    drive_idle();
    vecs[0] = '{9'd20,  11'h155, 9'd20,  11'h155};
    vecs[1] = '{9'd30,  11'h1A3, 9'd30,  11'h1A3};
    vecs[2] = '{9'd30,  11'h0F0, 9'd30,  11'h1A3};
    vecs[3] = '{9'd40,  11'h1A3, 9'd40,  11'h1A3};
    vecs[4] = '{9'd40,  11'h122, 9'd40,  11'h122};
    vecs[5] = '{9'd0,   11'h011, 9'd0,   11'h011};
    vecs[6] = '{9'd319, 11'h2F1, 9'd319, 11'h2F1};
    vecs[7] = '{9'd330, 11'h3FF, 9'd330, 11'h000};

    reset_init();

    // Both banks blank after init
    zero_exp();
    run_line(9'd8, 1'b0, 384);
    run_line(9'd9, 1'b0, 384);

    // Draw the table during line 10, show it on line 11
    zero_exp();
    for (int i = 0; i < 8; i++) add_wr(vecs[i].wx, vecs[i].wd);
    run_line(9'd10, 1'b0, 384);
    chk("wq_drained", wq.size(), 0);

    zero_exp();
    for (int i = 0; i < 8; i++) exp_disp[vecs[i].cx] = vecs[i].cexp;
    add_wr(9'd50, 11'h1B7);
    run_line(9'd11, 1'b0, 384);

    // x=50 shown under vblank: masked but still cleared
    zero_exp();
    run_line(9'd12, 1'b1, 384);

    // Table bank comes back cleared; out-of-range write dropped; vc wraps
    zero_exp();
    add_wr(9'd400, 11'h155);
    run_line(9'd511, 1'b0, 384);

    zero_exp();
    add_wr(9'd99, 11'h1C5);
    run_line(9'd0, 1'b0, 384);

    // Reset at hc=100 with pending draws in the other bank
    zero_exp();
    exp_disp[99] = 11'h1C5;
    add_wr(9'd60, 11'h1C5);
    add_wr(9'd70, 11'h2A9);
    run_line(9'd1, 1'b0, 100);
    flush();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_pix_out", bus.pix_out, 0);
    chk("midrst_init_done", bus.init_done, 0);
    chk("midrst_line_req", bus.line_req, 0);
    chk("midrst_line_num", bus.line_num, 0);
    reset_init();

    zero_exp();
    run_line(9'd2, 1'b0, 384);
    run_line(9'd3, 1'b0, 384);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_linebuf.md
Name: sprite_linebuf

Overview:
- Double-buffered sprite line buffer; sits directly downstream of the video timing generator.
- Consumes pixel enable, hc, hbl and vbl. The sprite renderer writes the next scanline into one bank while the other bank is scanned out at hc.
- Each displayed entry is cleared in the cycle after it is read, so the bank is blank when it becomes the draw bank again.
- Banks swap on hblank entry; a line request pulse tells the sprite renderer which line to draw next.

Parameters:
- PIX_W, 11, pixel width (7-bit palette + 4-bit colour code); colour code 0 is transparent.
- AW, 9, address width; each bank has 2^AW entries.
- XMAX, 383, highest valid x (equals the line length minus 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_pix  in  1  pixel enable, one clk wide; guaranteed at least one idle clk between enables.
- hc  in  9  horizontal counter.
- vc  in  9  vertical counter.
- hbl  in  1  horizontal blank.
- vbl  in  1  vertical blank.
- wr_en  in  1  renderer write strobe (fire-and-forget).
- wr_x  in  9  write x.
- wr_data  in  PIX_W  write pixel.
- line_req  out  1  one-clk pulse: start drawing the next line.
- line_num  out  9  line to draw, valid with line_req.
- pix_out  out  PIX_W  displayed sprite pixel; 0 = none.
- init_done  out  1  high once both banks have been cleared after reset.

Behaviour:
- Reset (async, reset_n=0) sets:
  - state=INIT, init_addr=0, bank_sel=0, pix_out=0, line_req=0, line_num=0, init_done=0, hbl_d=0.
  - Memory contents are undefined at reset.
- States:
  - INIT: each clk writes 0 to address init_addr in both banks, then increments init_addr. After address 2^AW-1, go to RUN and set init_done=1 (2^AW clks after reset release). In INIT, wr_en is ignored and pix_out is held at 0.
  - RUN: no exit except reset.
- Banks: bank_sel selects the display bank; the draw bank is !bank_sel. Each bank is single-port RAM; display and draw never address the same bank.
- Draw writes (RUN only), on any clk with wr_en=1:
  - If wr_x>XMAX, drop the write.
  - If wr_data[3:0]==0 (transparent), drop the write; existing content stays.
  - Otherwise write wr_data to draw bank[wr_x]. The last write wins.
  - Writes are independent of clk_pix.
- Scan-out, on a clk with clk_pix=1 (RUN):
  - Read display bank[hc].
  - On the next clk: pix_out <= (hbl|vbl) ? 0 : rdata, and write 0 to display bank[hc] (clear-after-read).
  - Latency is 1 clk from the clk_pix edge to pix_out; pix_out holds between enables.
  - Reads and clears happen for every hc, including blanking, so all addresses 0..XMAX are cleared once per line.
- Swap, on a clk_pix cycle where hbl=1 and hbl_d=0 (hbl_d samples hbl on clk_pix):
  - bank_sel toggles at the end of that clk.
  - line_req=1 for exactly that clk; line_num=vc+1 (9-bit wrap; the renderer ignores out-of-range lines).
  - The read/clear issued in the same clk_pix cycle uses the pre-swap display bank.
  - A draw write in the swap clk goes to the pre-swap draw bank (it becomes the display bank).
  - A pending clear in the clk after the swap still targets the pre-swap display bank. The clear address and bank are latched with the read.
- Simultaneous events:
  - wr_en together with a scan read/clear: both proceed (different banks).
  - Swap during INIT is suppressed; the hbl_d edge detector still tracks hbl.
- reset_n asserted mid-line: immediate return to INIT. Any partially drawn line is discarded by the full clear.

Decomposition:
- Shared package:
  - PIX_W, AW, XMAX.
  - TRANSP_MASK (4'hF on bits [3:0]).
  - State enum {INIT, RUN}.
- One sub-module, linebuf_bank: a single-port 2^AW x PIX_W RAM with registered read, instantiated twice. Address and write-enable muxing stays in the top level.

Test Plan:
- Reset release → init_done rises exactly 512 clks later; pix_out=0 throughout. Afterwards, reading every x of both banks over two lines gives 0.
- Write x=20 data 0x155 during line n, then run timing to the swap → line_req pulse with line_num=n+1. On line n+1 with hc=20, pix_out=0x155 one clk after clk_pix. On line n+2 with hc=20, pix_out=0 (cleared).
- Write x=30 data 0x1A3, then x=30 data 0x0F0 (transparent) → 0x1A3 displayed. Write x=30 data 0x1A3 then 0x122 → 0x122 displayed.
- wr_x=400 data 0x155 → no effect; scan all addresses, none equal 0x155.
- Display x=50 with vbl=1 → pix_out=0, and the entry is still cleared. Next use of that bank shows 0 at x=50.
- Assert reset_n low at hc=100 of a line with pending draws → outputs return to reset values immediately. INIT repeats, and the stale pixels are never displayed.
